mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 16-bit, fixed-latency, pipelined main memory between three requesters: the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Grants one requester at a time. A fill is granted as an atomic 8-word burst covering one 16-byte block; a store is granted as a single-word write.
- Returning read data is broadcast to both caches; only the valid and done strobes of the granted requester fire.
- Sits between the cache fill FSMs and the memory model; arbiter stalls propagate to the pipeline through the caches' busy signals.

Parameters:
- MEM_LATENCY, 4, cycles from a read issue (mem_enable=1, mem_wr=0) to its mem_data_valid.
- WORDS_PER_BLOCK, 8, 2-byte words per cache block (block = 16 bytes).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_fill_req  in  1  I-cache miss; level, held until i_fill_done.
- i_fill_addr  in  16  I-cache miss address; stable while i_fill_req is high.
- d_fill_req  in  1  D-cache miss; level, held until d_fill_done.
- d_fill_addr  in  16  D-cache miss address.
- d_wr_req  in  1  D-cache store; level, held until d_wr_ack.
- d_wr_addr  in  16  store address.
- d_wr_data  in  16  store data.
- mem_data_in  in  16  read data from memory.
- mem_data_valid  in  1  read data valid from memory.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- fill_data  out  16  mem_data_in passed through to both caches.
- fill_word_idx  out  3  word index (0..7) of the current fill_data.
- i_fill_valid  out  1  fill_data belongs to the I-cache (data array write enable).
- i_fill_done  out  1  one-cycle pulse with the 8th I-cache word (tag write enable).
- d_fill_valid  out  1  same as i_fill_valid, for the D-cache.
- d_fill_done  out  1  same as i_fill_done, for the D-cache.
- d_wr_ack  out  1  one-cycle pulse in the cycle the store is issued.
- arb_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: asynchronous; state=IDLE, issue_cnt=0, ret_cnt=0, owner=NONE, last_fill=I. All outputs are 0 during and after reset.
- States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE, grant evaluated combinationally, in order:
  - d_wr_req -> WRITE.
  - Otherwise a fill request -> ISSUE. owner = the winner; base = addr & 16'hFFF0 is latched.
  - Otherwise stay in IDLE.
- ISSUE: runs 8 cycles.
  - mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt counts 0..7.
  - After issue_cnt=7 -> DRAIN.
  - The first read issues exactly 1 cycle after the IDLE cycle that saw the request.
- Return path, active in ISSUE and DRAIN:
  - Each mem_data_valid asserts owner's x_fill_valid that cycle, with fill_word_idx=ret_cnt, then increments ret_cnt.
  - The valid for word 7 also pulses x_fill_done; the next state is IDLE and ret_cnt clears.
  - Last word returns 7+MEM_LATENCY cycles after the first issue. Whole fill is 1+8+MEM_LATENCY cycles from request to IDLE.
- mem_data_valid while in IDLE or WRITE (e.g. stale returns after a reset) is ignored: no strobes, no counter change.
- WRITE: lasts 1 cycle.
  - mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1.
  - Next state is IDLE.
- Requests arriving mid-burst or mid-write are held by the requester and evaluated at the next IDLE.
- No back-to-back grants: every transaction returns to IDLE for at least 1 cycle. A requester clears its req on its done/ack edge, so it is low in that IDLE cycle.
- mem_wdata=0 and mem_addr=0 whenever mem_enable=0.
- A fill base is always 16-byte aligned, so base + 2*7 cannot carry out of the block. The address wraps modulo 2^16.
- Reset mid-burst: the burst is aborted immediately. No done pulse is issued; the requester re-requests after reset.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both fill requests are pending in IDLE, grant the requester that is not last_fill. last_fill updates on each fill grant.
- Undefined: fixed priority, D-fill over I-fill; last_fill is unused.
- Stores keep absolute priority in both builds.

Test Plan:
- I-fill alone: i_fill_req=1, i_fill_addr=16'h1236 at cycle 0.
  - Reads issue at 16'h1230..16'h123E in cycles 1..8.
  - i_fill_valid in cycles 5..12 with idx 0..7.
  - i_fill_done in cycle 12; arb_busy low in cycle 13.
- Store: d_wr_req=1, d_wr_addr=16'h0040, d_wr_data=16'hBEEF in IDLE.
  - Next cycle: mem_enable=1, mem_wr=1, mem_addr=16'h0040, mem_wdata=16'hBEEF, d_wr_ack=1.
- Simultaneous I-fill, D-fill and store in cycle 0:
  - WRITE in cycle 1.
  - D-fill (fixed priority) issues in cycles 3..10.
  - I-fill starts after d_fill_done.
- ARB_ROUND_ROBIN_EN defined, both fills held permanently high: grants alternate D, I, D, I across 4 bursts.
- Reset asserted mid-ISSUE at issue_cnt=3:
  - All outputs are 0 asynchronously.
  - Late mem_data_valid pulses produce no x_fill_valid.
  - A fresh request then completes normally.
- Store request during a D-fill DRAIN: store is held; d_wr_ack comes 2 cycles after d_fill_done (IDLE, then WRITE).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the caches, the arbiter and the main memory model.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_arbiter_if;
    logic        i_fill_req;
    logic [15:0] i_fill_addr;
    logic        d_fill_req;
    logic [15:0] d_fill_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        i_fill_valid;
    logic        i_fill_done;
    logic        d_fill_valid;
    logic        d_fill_done;
    logic        d_wr_ack;
    logic        arb_busy;

    modport slave (
        input  i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_data_in, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_wdata, fill_data, fill_word_idx,
        output i_fill_valid, i_fill_done, d_fill_valid, d_fill_done, d_wr_ack, arb_busy
    );

    modport master (
        output i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_data_in, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_wdata, fill_data, fill_word_idx,
        input  i_fill_valid, i_fill_done, d_fill_valid, d_fill_done, d_wr_ack, arb_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: I-fill / D-fill 8-word bursts and single-word D-cache stores.
// Optional macro ARB_ROUND_ROBIN_EN alternates the two fills; default is D-fill over I-fill.
module mem_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

    if (MEM_LATENCY < 1) begin : gLatencyCheck
        $error("mem_arbiter expects registered memory read data (MEM_LATENCY >= 1)");
    end

    logic [1:0]  state_q, state_d;
    logic [2:0]  issueCnt_q, issueCnt_d;
    logic [2:0]  retCnt_q, retCnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] base_q, base_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic        lastFillD_q, lastFillD_d;
`endif

    logic pickD;
    logic retFire;
    logic lastRet;

    // Returns only count while a burst is outstanding; stale data in IDLE/WRITE is dropped.
    assign retFire = (state_q == ISSUE || state_q == DRAIN) && bus.mem_data_valid;
    assign lastRet = retFire && (retCnt_q == LAST_WORD);

    always_comb begin
        state_d    = state_q;
        issueCnt_d = issueCnt_q;
        retCnt_d   = retCnt_q;
        owner_d    = owner_q;
        base_d     = base_q;
`ifdef ARB_ROUND_ROBIN_EN
        lastFillD_d = lastFillD_q;
        pickD       = bus.d_fill_req && (!bus.i_fill_req || !lastFillD_q);
`else
        pickD       = bus.d_fill_req;
`endif

        case (state_q)
            IDLE: begin
                if (bus.d_wr_req) begin
                    state_d = WRITE;
                end else if (bus.i_fill_req || bus.d_fill_req) begin
                    state_d    = ISSUE;
                    issueCnt_d = 3'd0;
                    owner_d    = pickD ? OWN_D : OWN_I;
                    base_d     = (pickD ? bus.d_fill_addr : bus.i_fill_addr) & 16'hFFF0;
`ifdef ARB_ROUND_ROBIN_EN
                    lastFillD_d = pickD;
`endif
                end
            end
            ISSUE: begin
                issueCnt_d = issueCnt_q + 3'd1;
                if (issueCnt_q == LAST_WORD) begin
                    state_d = DRAIN;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (retFire) begin
            retCnt_d = retCnt_q + 3'd1;
        end
        if (lastRet) begin
            state_d  = IDLE;
            retCnt_d = 3'd0;
            owner_d  = OWN_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            issueCnt_q <= 3'd0;
            retCnt_q   <= 3'd0;
            owner_q    <= OWN_NONE;
            base_q     <= 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
            lastFillD_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            issueCnt_q <= issueCnt_d;
            retCnt_q   <= retCnt_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
`ifdef ARB_ROUND_ROBIN_EN
            lastFillD_q <= lastFillD_d;
`endif
        end
    end

    assign bus.mem_enable    = (state_q == ISSUE) || (state_q == WRITE);
    assign bus.mem_wr        = (state_q == WRITE);
    assign bus.mem_addr      = (state_q == ISSUE) ? base_q + {12'd0, issueCnt_q, 1'b0} :
                               (state_q == WRITE) ? bus.d_wr_addr : 16'h0000;
    assign bus.mem_wdata     = (state_q == WRITE) ? bus.d_wr_data : 16'h0000;
    assign bus.d_wr_ack      = (state_q == WRITE);
    assign bus.arb_busy      = (state_q != IDLE);

    assign bus.fill_data     = retFire ? bus.mem_data_in : 16'h0000;
    assign bus.fill_word_idx = retFire ? retCnt_q : 3'd0;
    assign bus.i_fill_valid  = retFire && (owner_q == OWN_I);
    assign bus.i_fill_done   = lastRet && (owner_q == OWN_I);
    assign bus.d_fill_valid  = retFire && (owner_q == OWN_D);
    assign bus.d_fill_done   = lastRet && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vector table plus burst, reset and priority sequences.
// Memory behaves as a 4-cycle pipelined read returning ~address.
module tb_mem_arbiter;

    localparam int  LAT = 4;
    localparam bit  H   = 1'b1;
    localparam bit  L   = 1'b0;

    typedef logic [58:0] out_t;

    typedef struct {
        bit          iReq;
        bit          dReq;
        bit          wReq;
        logic [15:0] wAddr;
        logic [15:0] wData;
        out_t        exp;
    } vec_t;

    logic clk;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.MEM_LATENCY(4), .WORDS_PER_BLOCK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vecCount = 0;
    int          missCount = 0;
    int          cyc = 0;
    bit          issued [4096];
    logic [15:0] issAddr [4096];
    vec_t        vecs [17];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t mkOut(bit en, bit wr, logic [15:0] addr, logic [15:0] wdata,
                                   logic [15:0] fdata, logic [2:0] idx, bit iV, bit iD,
                                   bit dV, bit dD, bit ack, bit busy);
        return {en, wr, addr, wdata, fdata, idx, iV, iD, dV, dD, ack, busy};
    endfunction

    function automatic vec_t mkVec(bit iReq, bit dReq, bit wReq, logic [15:0] wAddr,
                                   logic [15:0] wData, out_t exp);
        vec_t v;
        v.iReq = iReq; v.dReq = dReq; v.wReq = wReq;
        v.wAddr = wAddr; v.wData = wData; v.exp = exp;
        return v;
    endfunction

    function automatic out_t getOut();
        return {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data,
                bus.fill_word_idx, bus.i_fill_valid, bus.i_fill_done, bus.d_fill_valid,
                bus.d_fill_done, bus.d_wr_ack, bus.arb_busy};
    endfunction

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = getOut();
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s (cycle %0d): got {en,wr,addr,wdata,fdata,idx,iV,iD,dV,dD,ack,busy}=%h, expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic driveMemory();
        if (cyc >= LAT && issued[cyc-LAT]) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = ~issAddr[cyc-LAT];
        end else begin
            bus.mem_data_valid = 1'b0;
            bus.mem_data_in    = 16'h0000;
        end
    endtask

    task automatic recordIssue();
        issued[cyc]  = bus.mem_enable && !bus.mem_wr;
        issAddr[cyc] = bus.mem_addr;
    endtask

    // One clock cycle: memory response, mid-cycle compare, advance past the next edge.
    task automatic applyStimulus(input string name, input out_t exp);
        driveMemory();
        #1;
        checkOutput(name, exp);
        recordIssue();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs a whole fill from its granting IDLE cycle (j=0) through the done cycle (j=12).
    task automatic expectFill(input bit isD, input logic [15:0] base, input bit keep,
                              input int wrAt, input string tag);
        for (int j = 0; j <= 12; j++) begin
            bit          en;
            bit          v;
            logic [15:0] a;
            logic [15:0] d;
            logic [2:0]  idx;
            bit          dn;
            en  = (j >= 1 && j <= 8);
            v   = (j >= 5);
            a   = en ? base + 16'(2 * (j - 1)) : 16'h0000;
            d   = v ? ~(base + 16'(2 * (j - 5))) : 16'h0000;
            idx = v ? 3'(j - 5) : 3'd0;
            dn  = (j == 12);
            if (j == wrAt) bus.d_wr_req = 1'b1;
            applyStimulus($sformatf("%s j=%0d", tag, j),
                          mkOut(en, L, a, 16'h0000, d, idx, v && !isD, dn && !isD,
                                v && isD, dn && isD, L, j != 0));
        end
        if (!keep) begin
            if (isD) bus.d_fill_req = 1'b0;
            else     bus.i_fill_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = mkVec(H, L, L, 16'h0, 16'h0, '0);
        vecs[1]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h1230, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        vecs[2]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h1232, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        vecs[3]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h1234, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        vecs[4]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h1236, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        vecs[5]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h1238, 16'h0, 16'hEDCF, 3'd0, H, L, L, L, L, H));
        vecs[6]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h123A, 16'h0, 16'hEDCD, 3'd1, H, L, L, L, L, H));
        vecs[7]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h123C, 16'h0, 16'hEDCB, 3'd2, H, L, L, L, L, H));
        vecs[8]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(H, L, 16'h123E, 16'h0, 16'hEDC9, 3'd3, H, L, L, L, L, H));
        vecs[9]  = mkVec(H, L, L, 16'h0, 16'h0, mkOut(L, L, 16'h0000, 16'h0, 16'hEDC7, 3'd4, H, L, L, L, L, H));
        vecs[10] = mkVec(H, L, L, 16'h0, 16'h0, mkOut(L, L, 16'h0000, 16'h0, 16'hEDC5, 3'd5, H, L, L, L, L, H));
        vecs[11] = mkVec(H, L, L, 16'h0, 16'h0, mkOut(L, L, 16'h0000, 16'h0, 16'hEDC3, 3'd6, H, L, L, L, L, H));
        vecs[12] = mkVec(H, L, L, 16'h0, 16'h0, mkOut(L, L, 16'h0000, 16'h0, 16'hEDC1, 3'd7, H, H, L, L, L, H));
        vecs[13] = mkVec(L, L, L, 16'h0, 16'h0, '0);
        vecs[14] = mkVec(L, L, H, 16'h0040, 16'hBEEF, '0);
        vecs[15] = mkVec(L, L, H, 16'h0040, 16'hBEEF, mkOut(H, H, 16'h0040, 16'hBEEF, 16'h0, 3'd0, L, L, L, L, H, H));
        vecs[16] = mkVec(L, L, L, 16'h0040, 16'hBEEF, '0);

        rst = 1'b1;
        bus.i_fill_req = 1'b0; bus.i_fill_addr = 16'h1236;
        bus.d_fill_req = 1'b0; bus.d_fill_addr = 16'h0000;
        bus.d_wr_req = 1'b0;   bus.d_wr_addr = 16'h0000; bus.d_wr_data = 16'h0000;
        bus.mem_data_in = 16'h0000; bus.mem_data_valid = 1'b0;
        #2;
        checkOutput("reset", '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table: lone I-fill at 16'h1236, then a lone store.
        for (int i = 0; i < 17; i++) begin
            bus.i_fill_req = vecs[i].iReq;
            bus.d_fill_req = vecs[i].dReq;
            bus.d_wr_req   = vecs[i].wReq;
            bus.d_wr_addr  = vecs[i].wAddr;
            bus.d_wr_data  = vecs[i].wData;
            applyStimulus($sformatf("vec%0d", i), vecs[i].exp);
        end

        // All three requesters at once: store, then D-fill, then I-fill.
        bus.i_fill_addr = 16'h1236;
        bus.d_fill_addr = 16'h2468;
        bus.d_wr_addr   = 16'h0100;
        bus.d_wr_data   = 16'h1234;
        bus.i_fill_req  = 1'b1;
        bus.d_fill_req  = 1'b1;
        bus.d_wr_req    = 1'b1;
        applyStimulus("simul idle", '0);
        applyStimulus("simul write", mkOut(H, H, 16'h0100, 16'h1234, 16'h0, 3'd0, L, L, L, L, H, H));
        bus.d_wr_req = 1'b0;
        expectFill(1'b1, 16'h2460, 1'b0, -1, "simul dfill");
        expectFill(1'b0, 16'h1230, 1'b0, -1, "simul ifill");

        // Both fills held high back to back.
        bus.i_fill_req = 1'b1;
        bus.d_fill_req = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        expectFill(1'b1, 16'h2460, 1'b1, -1, "rr d1");
        expectFill(1'b0, 16'h1230, 1'b1, -1, "rr i1");
        expectFill(1'b1, 16'h2460, 1'b1, -1, "rr d2");
        expectFill(1'b0, 16'h1230, 1'b0, -1, "rr i2");
        bus.d_fill_req = 1'b0;
`else
        expectFill(1'b1, 16'h2460, 1'b1, -1, "prio d1");
        expectFill(1'b1, 16'h2460, 1'b0, -1, "prio d2");
        expectFill(1'b0, 16'h1230, 1'b0, -1, "prio i");
`endif
        applyStimulus("fills released", '0);

        // Store raised during the D-fill drain waits for done, one IDLE, then WRITE.
        bus.d_fill_addr = 16'hFFF6;
        bus.d_wr_addr   = 16'h0842;
        bus.d_wr_data   = 16'hCAFE;
        bus.d_fill_req  = 1'b1;
        expectFill(1'b1, 16'hFFF0, 1'b0, 10, "drain dfill");
        applyStimulus("held store idle", '0);
        applyStimulus("held store write", mkOut(H, H, 16'h0842, 16'hCAFE, 16'h0, 3'd0, L, L, L, L, H, H));
        bus.d_wr_req = 1'b0;
        applyStimulus("after store", '0);

        // Reset in the issue_cnt=3 cycle of an I-fill; late returns must be ignored.
        bus.i_fill_addr = 16'h7778;
        bus.i_fill_req  = 1'b1;
        applyStimulus("rst j0", '0);
        applyStimulus("rst j1", mkOut(H, L, 16'h7770, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        applyStimulus("rst j2", mkOut(H, L, 16'h7772, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        applyStimulus("rst j3", mkOut(H, L, 16'h7774, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        driveMemory();
        #1;
        checkOutput("rst j4 issue", mkOut(H, L, 16'h7776, 16'h0, 16'h0, 3'd0, L, L, L, L, L, H));
        recordIssue();
        #1;
        rst = 1'b1;
        bus.i_fill_req = 1'b0;
        #1;
        checkOutput("rst async", '0);
        @(posedge clk);
        #1;
        cyc++;
        applyStimulus("rst held a", '0);
        applyStimulus("rst held b", '0);
        rst = 1'b0;
        applyStimulus("stale ret a", '0);
        applyStimulus("stale ret b", '0);
        bus.i_fill_addr = 16'h0A0C;
        bus.i_fill_req  = 1'b1;
        expectFill(1'b0, 16'h0A00, 1'b0, -1, "fresh ifill");
        applyStimulus("final idle", '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
